sync_memory: RTL

Single-clock, parametrised, byte-writable data memory with a registered read port and a built-in clear engine. It is the next-generation storage block for single-clock-domain datapaths. It adds per-byte write enables, a read-valid handshake, in-range address checking, and a self-sequenced zeroing pass after reset or on request. The zeroing pass replaces the old single-cycle reset of the whole array, which does not scale.

---
 rtl/sync_memory.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sync_memory.sv
// sync_memory: single-clock byte-writable data memory with a registered read
// port, read-valid pulse, address range checking and a self-sequenced clear
// engine that zeroes the whole array after reset or on request.
//
// Optional feature macro: MEMORY_BYPASS_EN
//   defined   -> write-first: a read of the address being written returns the
//                merged word (enabled lanes from data_in, others from storage)
//   undefined -> read-first: such a read returns the word stored before the write
module sync_memory #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 64,
    parameter int LSIZE = $clog2(SIZE),
    parameter int NBE   = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_req,
    output logic             busy,
    input  logic             wr_en,
    input  logic [LSIZE-1:0] wr_addr,
    input  logic [NBE-1:0]   wr_be,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    input  logic [LSIZE-1:0] rd_addr,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid
);

    // One extra bit so SIZE itself is representable for the range compare.
    localparam logic [LSIZE:0] SIZE_EXT = SIZE[LSIZE:0];
    localparam int             LAST     = SIZE - 1;
    localparam logic [LSIZE-1:0] LAST_PTR = LAST[LSIZE-1:0];

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LSIZE-1:0] clr_ptr_q, clr_ptr_d;
    logic             rd_valid_q;

    logic             clearing;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_in_range;
    logic             rd_in_range;
    logic [LSIZE-1:0] mem_addr;

    assign busy        = (state_q == CLEAR);
    assign clearing    = busy && rst_n;
    assign wr_fire     = wr_en && !busy;
    assign rd_fire     = rd_en && !busy;
    assign wr_in_range = ({1'b0, wr_addr} < SIZE_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < SIZE_EXT);
    // The single write port is shared: the clear engine owns it while busy.
    assign mem_addr    = busy ? clr_ptr_q : wr_addr;
    assign rd_valid    = rd_valid_q;

`ifdef MEMORY_BYPASS_EN
    logic same_addr;
    assign same_addr = wr_fire && (wr_addr == rd_addr);
`endif

    // State, clear pointer and read-valid registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_valid_q <= rd_fire;
        end
    end

    // Next-state: walk the clear pointer to the last word, or start a pass on request
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Storage is split into independent byte lanes so each lane is a plain
    // single-write-port RAM with its own enable.
    for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
        logic [7:0] mem_lane [SIZE];
        logic [7:0] rd_lane_q;
        logic       lane_we;
        logic [7:0] lane_wdata;

        assign lane_we    = clearing || (wr_fire && wr_in_range && wr_be[gi]);
        assign lane_wdata = busy ? 8'h00 : data_in[8*gi +: 8];

        // Lane write port (clear engine or user write)
        always_ff @(posedge clk) begin
            if (lane_we) begin
                mem_lane[mem_addr] <= lane_wdata;
            end
        end

        // Lane read register: zero for out-of-range, holds between reads
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_lane_q <= '0;
            end else if (rd_fire) begin
                if (!rd_in_range) begin
                    rd_lane_q <= '0;
`ifdef MEMORY_BYPASS_EN
                end else if (same_addr && wr_be[gi]) begin
                    rd_lane_q <= data_in[8*gi +: 8];
`endif
                end else begin
                    rd_lane_q <= mem_lane[rd_addr];
                end
            end
        end

        assign data_out[8*gi +: 8] = rd_lane_q;
    end

endmodule
